// File: rtl/bit_manip_dispatcher.sv
// Execute-stage front end for the bit-manipulation unit: forwards ops to the BMU or runs carry-less multiply serially.
// Optional feature macro: BITMANIP_CLMUL_EN (enables the iterative CLMUL/CLMULH/CLMULR engine).
module bit_manip_dispatcher #(
  parameter int XLEN        = 32,
  parameter int CLMUL_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      bitOp_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic [4:0]      rd_i,
  output logic [4:0]      bmu_op_o,
  output logic [XLEN-1:0] bmu_op1_o,
  output logic [XLEN-1:0] bmu_op2_o,
  input  logic [XLEN-1:0] bmu_result_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam logic [4:0] OP_CLMUL  = 5'd29;
  localparam logic [4:0] OP_CLMULH = 5'd30;
  localparam logic [4:0] OP_CLMULR = 5'd31;

  if (XLEN != 32 || CLMUL_STEPS != 32) begin : g_cfg_check
    $error("bit_manip_dispatcher supports only XLEN=32 and CLMUL_STEPS=32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COMB  = 2'd1,
`ifdef BITMANIP_CLMUL_EN
    CLMUL = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            illegal_q, illegal_d;
  logic            accept;
  state_t          exec_state;

`ifdef BITMANIP_CLMUL_EN
  localparam logic [4:0] LAST_STEP = 5'(CLMUL_STEPS - 1);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [2*XLEN-1:0] sh1_q, sh1_d;
  logic [XLEN-1:0]   sh2_q, sh2_d;
  logic [4:0]        cnt_q, cnt_d;

  assign exec_state = (bitOp_i >= OP_CLMUL) ? CLMUL : COMB;
  assign acc_step   = sh2_q[0] ? (acc_q ^ sh1_q) : acc_q;
`else
  assign exec_state = COMB;
`endif

  assign accept = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      rd_out_q  <= '0;
      illegal_q <= 1'b0;
`ifdef BITMANIP_CLMUL_EN
      acc_q     <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      rd_out_q  <= rd_out_d;
      illegal_q <= illegal_d;
`ifdef BITMANIP_CLMUL_EN
      acc_q     <= acc_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = exec_state;
        COMB: state_d = DONE;
`ifdef BITMANIP_CLMUL_EN
        CLMUL: if (cnt_q == LAST_STEP) state_d = DONE;
`endif
        DONE: begin
          if (ready_i) state_d = accept ? exec_state : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    res_d     = res_q;
    rd_out_d  = rd_out_q;
    illegal_d = illegal_q;
`ifdef BITMANIP_CLMUL_EN
    acc_d     = acc_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    cnt_d     = cnt_q;
`endif

    if (accept) begin
      op_d  = bitOp_i;
      opa_d = operand1_i;
      opb_d = operand2_i;
      rd_d  = rd_i;
`ifdef BITMANIP_CLMUL_EN
      acc_d = '0;
      sh1_d = {{XLEN{1'b0}}, operand1_i};
      sh2_d = operand2_i;
      cnt_d = '0;
`endif
    end

    // Result and destination are captured only on completion so DONE holds them while a new op is latched.
    if (!flush_i) begin
      case (state_q)
        COMB: begin
          rd_out_d  = rd_q;
`ifdef BITMANIP_CLMUL_EN
          res_d     = bmu_result_i;
          illegal_d = 1'b0;
`else
          res_d     = (op_q >= OP_CLMUL) ? '0 : bmu_result_i;
          illegal_d = (op_q >= OP_CLMUL);
`endif
        end
`ifdef BITMANIP_CLMUL_EN
        CLMUL: begin
          acc_d = acc_step;
          sh1_d = sh1_q << 1;
          sh2_d = sh2_q >> 1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            rd_out_d  = rd_q;
            illegal_d = 1'b0;
            case (op_q)
              OP_CLMULH: res_d = acc_step[63:32];
              OP_CLMULR: res_d = acc_step[62:31];
              default:   res_d = acc_step[31:0];
            endcase
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    ready_o   = rst_i && !flush_i && ((state_q == IDLE) || ((state_q == DONE) && ready_i));
    valid_o   = (state_q == DONE);
    busy_o    = (state_q != IDLE);
    bmu_op_o  = op_q;
    bmu_op1_o = opa_q;
    bmu_op2_o = opb_q;
    result_o  = res_q;
    rd_o      = rd_out_q;
    illegal_o = illegal_q;
  end

endmodule

// File: tb/tb_bit_manip_dispatcher.sv
// Directed self-checking bench for bit_manip_dispatcher; CLMUL vectors run when BITMANIP_CLMUL_EN is defined.
module tb_bit_manip_dispatcher;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o, illegal_o, busy_o;
  logic [4:0]  bitOp_i, rd_i, bmu_op_o, rd_o;
  logic [31:0] operand1_i, operand2_i, bmu_op1_o, bmu_op2_o, bmu_result_i, result_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  // Stand-in BMU: 0 ANDN, 1 OR, 2 XOR, otherwise ADD.
  always_comb begin
    case (bmu_op_o)
      5'd0:    bmu_result_i = bmu_op1_o & ~bmu_op2_o;
      5'd1:    bmu_result_i = bmu_op1_o | bmu_op2_o;
      5'd2:    bmu_result_i = bmu_op1_o ^ bmu_op2_o;
      default: bmu_result_i = bmu_op1_o + bmu_op2_o;
    endcase
  end

  bit_manip_dispatcher dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .bitOp_i(bitOp_i), .operand1_i(operand1_i), .operand2_i(operand2_i), .rd_i(rd_i),
    .bmu_op_o(bmu_op_o), .bmu_op1_o(bmu_op1_o), .bmu_op2_o(bmu_op2_o), .bmu_result_i(bmu_result_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .rd_o(rd_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  task tick;
    @(posedge clk_i);
    #1;
  endtask

  // Presents an op and returns just after the accepting edge.
  task issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n;
    valid_i = 1'b1; bitOp_i = op; operand1_i = a; operand2_i = b; rd_i = rd;
    #1;
    n = 0;
    while (!ready_o && n < 50) begin tick; n++; end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready: ready_o=%b required 1", ready_o); end
    tick;
    valid_i = 1'b0; operand1_i = 32'hDEAD_BEEF; operand2_i = 32'hCAFE_F00D;
  endtask

  task wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 100) begin tick; lat++; end
    $display("txn: op=%0d result=%h rd=%0d illegal=%b latency=%0d", bmu_op_o, result_o, rd_o, illegal_o, lat);
  endtask

  task check_reset_outputs(input string tag);
    checks++;
    if ({ready_o, valid_o, busy_o, illegal_o} !== 4'b0000) begin
      errors++; $display("FAIL %s_flags: ready/valid/busy/illegal=%b required 0000", tag, {ready_o, valid_o, busy_o, illegal_o});
    end
    checks++;
    if (result_o !== 32'h0 || rd_o !== 5'h0) begin
      errors++; $display("FAIL %s_result: result_o=%h rd_o=%0d required 0/0", tag, result_o, rd_o);
    end
    checks++;
    if (bmu_op_o !== 5'h0 || bmu_op1_o !== 32'h0 || bmu_op2_o !== 32'h0) begin
      errors++; $display("FAIL %s_bmu: op=%0d op1=%h op2=%h required all 0", tag, bmu_op_o, bmu_op1_o, bmu_op2_o);
    end
  endtask

  task test_reset;
    rst_i = 1'b0;
    tick; tick;
    check_reset_outputs("reset");
    rst_i = 1'b1;
    tick;
  endtask

  task test_bmu_op;
    int lat;
    ready_i = 1'b1;
    issue(5'd0, 32'hA5A5_FFFF, 32'h0000_F0F0, 5'd7);
    checks++;
    if (bmu_op1_o !== 32'hA5A5_FFFF || bmu_op2_o !== 32'h0000_F0F0) begin
      errors++; $display("FAIL bmu_latched: op1=%h op2=%h required a5a5ffff/0000f0f0", bmu_op1_o, bmu_op2_o);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL bmu_latency: got %0d required 1", lat); end
    checks++;
    if (result_o !== 32'hA5A5_0F0F || rd_o !== 5'd7 || illegal_o !== 1'b0) begin
      errors++; $display("FAIL bmu_result: result=%h rd=%0d illegal=%b required a5a50f0f/7/0", result_o, rd_o, illegal_o);
    end
    tick;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL bmu_drain: valid=%b busy=%b required 0/0", valid_o, busy_o);
    end
  endtask

`ifdef BITMANIP_CLMUL_EN
  task test_clmul;
    logic [4:0]  vop[4] = '{5'd29, 5'd30, 5'd31, 5'd29};
    logic [31:0] va[4]  = '{32'h0000_0003, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb[4]  = '{32'h0000_0003, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] vexp[4] = '{32'h0000_0005, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
    int lat;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(vop[i], va[i], vb[i], 5'(i + 1));
      wait_valid(lat);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL clmul_latency[%0d]: got %0d required 32", i, lat); end
      checks++;
      if (result_o !== vexp[i] || rd_o !== 5'(i + 1) || illegal_o !== 1'b0) begin
        errors++; $display("FAIL clmul_result[%0d]: result=%h rd=%0d illegal=%b required %h/%0d/0", i, result_o, rd_o, illegal_o, vexp[i], i + 1);
      end
      tick;
    end
  endtask
`else
  task test_illegal;
    int lat;
    ready_i = 1'b1;
    issue(5'd30, 32'h0000_1234, 32'h0000_5678, 5'd12);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d required 1", lat); end
    checks++;
    if (result_o !== 32'h0 || illegal_o !== 1'b1 || rd_o !== 5'd12) begin
      errors++; $display("FAIL illegal_result: result=%h illegal=%b rd=%0d required 0/1/12", result_o, illegal_o, rd_o);
    end
    tick;
  endtask
`endif

  task test_backpressure;
    int lat;
    ready_i = 1'b0;
    issue(5'd1, 32'h1234_0000, 32'h0000_5678, 5'd9);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d required 1", lat); end
    valid_i = 1'b1; bitOp_i = 5'd2; operand1_i = 32'hFFFF_0000; operand2_i = 32'h0F0F_0F0F; rd_i = 5'd3;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'h1234_5678 || rd_o !== 5'd9) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%h rd=%0d required 1/0/12345678/9", c, valid_o, ready_o, result_o, rd_o);
      end
      tick;
    end
    ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: ready_o=%b required 1", ready_o); end
    tick;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1 || bmu_op1_o !== 32'hFFFF_0000) begin
      errors++; $display("FAIL bp_reaccept: valid=%b busy=%b op1=%h required 0/1/ffff0000", valid_o, busy_o, bmu_op1_o);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 1 || result_o !== 32'hF0F0_0F0F || rd_o !== 5'd3) begin
      errors++; $display("FAIL bp_second: lat=%0d result=%h rd=%0d required 1/f0f00f0f/3", lat, result_o, rd_o);
    end
    tick;
  endtask

  task test_back_to_back;
    int nres;
    ready_i = 1'b1;
    valid_i = 1'b1; bitOp_i = 5'd3; operand1_i = 32'd1; operand2_i = 32'd2; rd_i = 5'd4;
    nres = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (valid_o) nres++;
    end
    valid_i = 1'b0;
    checks++;
    if (nres !== 5 || result_o !== 32'd3) begin
      errors++; $display("FAIL b2b_throughput: results=%0d last=%h required 5/00000003", nres, result_o);
    end
    tick;
  endtask

  task test_flush;
    logic seen;
    ready_i = 1'b1;
`ifdef BITMANIP_CLMUL_EN
    issue(5'd29, 32'h0000_0003, 32'h0000_0003, 5'd5);
    repeat (9) tick;
`else
    issue(5'd2, 32'h0000_00FF, 32'h0000_0F0F, 5'd5);
`endif
    flush_i = 1'b1;
    valid_i = 1'b1; bitOp_i = 5'd1; operand1_i = 32'h1; operand2_i = 32'h2; rd_i = 5'd8;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: ready_o=%b required 0", ready_o); end
    tick;
    flush_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy=%b valid=%b required 0/0", busy_o, valid_o);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin tick; seen |= valid_o; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: valid_o rose=%b required 0", seen); end
  endtask

  task test_reset_mid;
    int lat;
    ready_i = 1'b1;
    issue(5'd2, 32'hFFFF_0000, 32'h0000_FFFF, 5'd17);
    rst_i = 1'b0;
    tick;
    check_reset_outputs("rst_comb");
    rst_i = 1'b1;
    ready_i = 1'b0;
    issue(5'd1, 32'h0000_00F0, 32'h0000_0F00, 5'd21);
    wait_valid(lat);
    checks++;
    if (valid_o !== 1'b1 || result_o !== 32'h0000_0FF0) begin
      errors++; $display("FAIL rst_pre_done: valid=%b result=%h required 1/00000ff0", valid_o, result_o);
    end
    rst_i = 1'b0;
    tick;
    check_reset_outputs("rst_done");
    rst_i = 1'b1;
    ready_i = 1'b1;
    tick;
    issue(5'd0, 32'hF0F0_F0F0, 32'h00FF_00FF, 5'd6);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || result_o !== 32'hF000_F000 || rd_o !== 5'd6 || illegal_o !== 1'b0) begin
      errors++; $display("FAIL rst_after: lat=%0d result=%h rd=%0d illegal=%b required 1/f000f000/6/0", lat, result_o, rd_o, illegal_o);
    end
    tick;
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    bitOp_i = '0; operand1_i = '0; operand2_i = '0; rd_i = '0;
    test_reset;
    test_bmu_op;
`ifdef BITMANIP_CLMUL_EN
    test_clmul;
`else
    test_illegal;
`endif
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
